// File: rtl/maindec_mc.sv
// Multi-cycle MIPS main decoder: fetch/decode/execute FSM with extended
// opcodes, 3-bit ALUOp, zero-extend select, memory stall handshake and
// illegal-opcode reporting. All control outputs decode from state, op, memready.
module maindec_mc #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_EXT    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       memreq,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       branch,
  output logic       bne,
  output logic       extop,
  output logic       illegal,
  output logic [1:0] memtoreg,
  output logic [1:0] regdst,
  output logic [1:0] pcsrc,
  output logic [1:0] alusrcb,
  output logic [2:0] aluop,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    IEXEC    = 4'd9,
    IWB      = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  state_t state_q;
  state_t state_d;
  logic   rdy;
  logic   is_lw, is_sw, is_r, is_beq, is_bne, is_addi;
  logic   is_slti, is_andi, is_ori, is_j, is_jal;

  // Without the handshake, memory is assumed to complete every cycle
  assign rdy = MEM_HANDSHAKE ? memready : 1'b1;

  // Opcode match; extended opcodes exist only when enabled
  always_comb begin
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_r    = (op == OP_R);
    is_beq  = (op == OP_BEQ);
    is_addi = (op == OP_ADDI);
    is_j    = (op == OP_J);
    is_bne  = ENABLE_EXT && (op == OP_BNE);
    is_slti = ENABLE_EXT && (op == OP_SLTI);
    is_andi = ENABLE_EXT && (op == OP_ANDI);
    is_ori  = ENABLE_EXT && (op == OP_ORI);
    is_jal  = ENABLE_EXT && (op == OP_JAL);
  end

  // State register, asynchronous reset to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and control decode
  always_comb begin
    state_d  = FETCH;
    memreq   = 1'b0;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;
    extop    = 1'b0;
    illegal  = 1'b0;
    memtoreg = 2'b00;
    regdst   = 2'b00;
    pcsrc    = 2'b00;
    alusrcb  = 2'b00;
    aluop    = 3'b000;
    case (state_q)
      FETCH: begin
        memreq  = 1'b1;
        alusrcb = 2'b01;
        irwrite = rdy;
        pcwrite = rdy;
        state_d = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        if (is_lw || is_sw)                        state_d = MEMADR;
        else if (is_r)                             state_d = EXECUTE;
        else if (is_beq || is_bne)                 state_d = BRANCH;
        else if (is_addi || is_slti || is_andi || is_ori) state_d = IEXEC;
        else if (is_j)                             state_d = JUMP;
        else if (is_jal)                           state_d = JAL;
        else begin
          illegal = 1'b1;
          state_d = FETCH;
        end
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (is_lw)      state_d = MEMREAD;
        else if (is_sw) state_d = MEMWRITE;
        else            state_d = FETCH;
      end
      MEMREAD: begin
        iord    = 1'b1;
        memreq  = 1'b1;
        state_d = rdy ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
      end
      MEMWRITE: begin
        iord     = 1'b1;
        memreq   = 1'b1;
        memwrite = 1'b1;
        state_d  = rdy ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 3'b010;
        state_d = ALUWB;
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 3'b001;
        pcsrc   = 2'b01;
        branch  = is_beq;
        bne     = is_bne;
      end
      IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        extop   = is_andi || is_ori;
        if (is_slti)      aluop = 3'b101;
        else if (is_andi) aluop = 3'b011;
        else if (is_ori)  aluop = 3'b100;
        else              aluop = 3'b000;
        state_d = IWB;
      end
      IWB: begin
        regwrite = 1'b1;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      JAL: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        regwrite = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
      end
      default: state_d = FETCH;
    endcase
  end

  assign state = 4'(state_q);

endmodule

// File: tb/tb_maindec_mc.sv
// Bench for maindec_mc: two instances (full-featured, and legacy without
// handshake/extensions) driven by instruction-level random stimulus and
// compared each cycle against an expected per-instruction step sequence.
module tb_maindec_mc;

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MWR = 5,
                 S_EX = 6, S_AW = 7, S_BR = 8, S_IE = 9, S_IW = 10, S_J = 11,
                 S_JAL = 12;

  typedef enum int {C_LW, C_SW, C_R, C_BEQ, C_BNE, C_ADDI, C_SLTI, C_ANDI,
                    C_ORI, C_J, C_JAL, C_ILL} cls_t;

  typedef struct packed {
    logic [3:0] state;
    logic memreq, pcwrite, irwrite, regwrite, memwrite, iord, alusrca;
    logic branch, bne, extop, illegal;
    logic [1:0] memtoreg, regdst, pcsrc, alusrcb;
    logic [2:0] aluop;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] op_a, op_b;
  logic memready_a, memready_b;

  logic memreq_a, pcwrite_a, irwrite_a, regwrite_a, memwrite_a, iord_a, alusrca_a;
  logic branch_a, bne_a, extop_a, illegal_a;
  logic [1:0] memtoreg_a, regdst_a, pcsrc_a, alusrcb_a;
  logic [2:0] aluop_a;
  logic [3:0] state_a;

  logic memreq_b, pcwrite_b, irwrite_b, regwrite_b, memwrite_b, iord_b, alusrca_b;
  logic branch_b, bne_b, extop_b, illegal_b;
  logic [1:0] memtoreg_b, regdst_b, pcsrc_b, alusrcb_b;
  logic [2:0] aluop_b;
  logic [3:0] state_b;

  int vectors = 0;
  int errors  = 0;

  int   qs[$];
  logic qr[$];
  logic qm[$];

  logic [5:0] legal_ops [11] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                 6'b000101, 6'b001000, 6'b001010, 6'b001100,
                                 6'b001101, 6'b000010, 6'b000011};

  maindec_mc #(.MEM_HANDSHAKE(1'b1), .ENABLE_EXT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .op(op_a), .memready(memready_a),
    .memreq(memreq_a), .pcwrite(pcwrite_a), .irwrite(irwrite_a),
    .regwrite(regwrite_a), .memwrite(memwrite_a), .iord(iord_a),
    .alusrca(alusrca_a), .branch(branch_a), .bne(bne_a), .extop(extop_a),
    .illegal(illegal_a), .memtoreg(memtoreg_a), .regdst(regdst_a),
    .pcsrc(pcsrc_a), .alusrcb(alusrcb_a), .aluop(aluop_a), .state(state_a)
  );

  maindec_mc #(.MEM_HANDSHAKE(1'b0), .ENABLE_EXT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .op(op_b), .memready(memready_b),
    .memreq(memreq_b), .pcwrite(pcwrite_b), .irwrite(irwrite_b),
    .regwrite(regwrite_b), .memwrite(memwrite_b), .iord(iord_b),
    .alusrca(alusrca_b), .branch(branch_b), .bne(bne_b), .extop(extop_b),
    .illegal(illegal_b), .memtoreg(memtoreg_b), .regdst(regdst_b),
    .pcsrc(pcsrc_b), .alusrcb(alusrcb_b), .aluop(aluop_b), .state(state_b)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, required done");
    $fatal(1);
  end

  task automatic check_ctl(input string tag, input logic [25:0] got, input logic [25:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t get_obs(input int inst);
    if (inst == 0)
      return ctl_t'({state_a, memreq_a, pcwrite_a, irwrite_a, regwrite_a, memwrite_a,
                     iord_a, alusrca_a, branch_a, bne_a, extop_a, illegal_a,
                     memtoreg_a, regdst_a, pcsrc_a, alusrcb_a, aluop_a});
    return ctl_t'({state_b, memreq_b, pcwrite_b, irwrite_b, regwrite_b, memwrite_b,
                   iord_b, alusrca_b, branch_b, bne_b, extop_b, illegal_b,
                   memtoreg_b, regdst_b, pcsrc_b, alusrcb_b, aluop_b});
  endfunction

  function automatic cls_t classify(input logic [5:0] o, input bit ext);
    case (o)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return C_R;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      6'b000101: return ext ? C_BNE  : C_ILL;
      6'b001010: return ext ? C_SLTI : C_ILL;
      6'b001100: return ext ? C_ANDI : C_ILL;
      6'b001101: return ext ? C_ORI  : C_ILL;
      6'b000011: return ext ? C_JAL  : C_ILL;
      default:   return C_ILL;
    endcase
  endfunction

  // Expected control word for one step of an instruction of class c
  function automatic ctl_t exp_ctl(input int s, input cls_t c, input logic rdy);
    ctl_t e;
    e = '0;
    e.state = 4'(s);
    case (s)
      S_F:   begin e.memreq = 1; e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy; end
      S_D:   begin e.alusrcb = 2'b11; e.illegal = (c == C_ILL); end
      S_MA:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_MR:  begin e.iord = 1; e.memreq = 1; end
      S_MWB: begin e.regwrite = 1; e.memtoreg = 2'b01; end
      S_MWR: begin e.iord = 1; e.memreq = 1; e.memwrite = 1; end
      S_EX:  begin e.alusrca = 1; e.aluop = 3'b010; end
      S_AW:  begin e.regwrite = 1; e.regdst = 2'b01; end
      S_BR:  begin
        e.alusrca = 1; e.aluop = 3'b001; e.pcsrc = 2'b01;
        e.branch = (c == C_BEQ); e.bne = (c == C_BNE);
      end
      S_IE:  begin
        e.alusrca = 1; e.alusrcb = 2'b10;
        e.aluop = (c == C_SLTI) ? 3'b101 : (c == C_ANDI) ? 3'b011 :
                  (c == C_ORI) ? 3'b100 : 3'b000;
        e.extop = (c == C_ANDI) || (c == C_ORI);
      end
      S_IW:  e.regwrite = 1;
      S_J:   begin e.pcsrc = 2'b10; e.pcwrite = 1; end
      S_JAL: begin
        e.pcsrc = 2'b10; e.pcwrite = 1; e.regwrite = 1;
        e.regdst = 2'b10; e.memtoreg = 2'b10;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Append one step; memory steps on the handshake instance get wait cycles first
  task automatic add_step(input int s, input int waits, input bit mem, input int inst);
    if (mem && inst == 0) begin
      for (int k = 0; k < waits; k++) begin qs.push_back(s); qr.push_back(1'b0); qm.push_back(1'b0); end
      qs.push_back(s); qr.push_back(1'b1); qm.push_back(1'b1);
    end else begin
      qs.push_back(s); qr.push_back(1'b1); qm.push_back(1'($urandom));
    end
  endtask

  // Run one instruction from FETCH; rst_at >= 0 asserts reset at that step
  task automatic run_instr(input int inst, input logic [5:0] opv, input int fw,
                           input int mw, input int rst_at);
    cls_t c;
    int   pcw;
    ctl_t g;
    c = classify(opv, inst == 0);
    qs.delete(); qr.delete(); qm.delete();
    add_step(S_F, fw, 1'b1, inst);
    add_step(S_D, 0, 1'b0, inst);
    case (c)
      C_LW:   begin add_step(S_MA, 0, 0, inst); add_step(S_MR, mw, 1, inst); add_step(S_MWB, 0, 0, inst); end
      C_SW:   begin add_step(S_MA, 0, 0, inst); add_step(S_MWR, mw, 1, inst); end
      C_R:    begin add_step(S_EX, 0, 0, inst); add_step(S_AW, 0, 0, inst); end
      C_BEQ, C_BNE: add_step(S_BR, 0, 0, inst);
      C_ADDI, C_SLTI, C_ANDI, C_ORI: begin add_step(S_IE, 0, 0, inst); add_step(S_IW, 0, 0, inst); end
      C_J:    add_step(S_J, 0, 0, inst);
      C_JAL:  add_step(S_JAL, 0, 0, inst);
      default: ;
    endcase
    pcw = 0;
    foreach (qs[i]) begin
      if (inst == 0) begin op_a = opv; memready_a = qm[i]; end
      else begin op_b = opv; memready_b = qm[i]; end
      #1;
      g = get_obs(inst);
      check_ctl($sformatf("i%0d_op%b_step%0d_st%0d", inst, opv, i, qs[i]), g, exp_ctl(qs[i], c, qr[i]));
      pcw += int'(g.pcwrite);
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        check_ctl("async_rst", get_obs(inst), exp_ctl(S_F, c, (inst == 0) ? qm[i] : 1'b1));
        @(negedge clk);
        #1;
        check_ctl("rst_hold", get_obs(inst), exp_ctl(S_F, c, (inst == 0) ? qm[i] : 1'b1));
        reset = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check_ctl($sformatf("pcwrite_cnt_i%0d_op%b", inst, opv), 26'(pcw),
              26'((c == C_J || c == C_JAL) ? 2 : 1));
  endtask

  initial begin
    logic [5:0] ro;
    reset = 1'b1;
    op_a = 6'b000000; memready_a = 1'b1;
    op_b = 6'b000000; memready_b = 1'b1;
    @(negedge clk);
    #1;
    check_ctl("reset_a", get_obs(0), exp_ctl(S_F, C_R, 1'b1));
    check_ctl("reset_b", get_obs(1), exp_ctl(S_F, C_R, 1'b1));
    memready_a = 1'b0;
    memready_b = 1'b0;
    #1;
    check_ctl("reset_a_nordy", get_obs(0), exp_ctl(S_F, C_R, 1'b0));
    check_ctl("reset_b_nordy", get_obs(1), exp_ctl(S_F, C_R, 1'b1));
    memready_a = 1'b1;
    memready_b = 1'b1;
    reset = 1'b0;

    // Full-featured instance: directed then random
    run_instr(0, 6'b000000, 0, 0, -1);
    run_instr(0, 6'b100011, 2, 3, -1);
    run_instr(0, 6'b101011, 0, 0, -1);
    run_instr(0, 6'b001101, 0, 0, -1);
    run_instr(0, 6'b000101, 0, 0, -1);
    run_instr(0, 6'b000011, 0, 0, -1);
    run_instr(0, 6'b000100, 0, 0, -1);
    run_instr(0, 6'b111111, 0, 0, -1);
    run_instr(0, 6'b101011, 1, 2, -1);
    run_instr(0, 6'b100011, 0, 3, 4);
    run_instr(0, 6'b001010, 1, 0, -1);
    for (int n = 0; n < 150; n++) begin
      ro = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 10)];
      run_instr(0, ro, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    // Legacy instance
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_ctl("reset_b2", get_obs(1), exp_ctl(S_F, C_R, 1'b1));
    reset = 1'b0;
    run_instr(1, 6'b001101, 0, 0, -1);
    run_instr(1, 6'b000101, 0, 0, -1);
    run_instr(1, 6'b000011, 0, 0, -1);
    run_instr(1, 6'b001000, 0, 0, -1);
    run_instr(1, 6'b100011, 0, 0, -1);
    run_instr(1, 6'b101011, 0, 0, -1);
    run_instr(1, 6'b000010, 0, 0, -1);
    for (int n = 0; n < 150; n++) begin
      ro = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 10)];
      run_instr(1, ro, 0, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
